// File: rtl/instr_issue_pkg.sv
// Shared types and constants for the instruction issue unit.
// The optional feature macro ISSUE_OPCODE_FILTER_EN is consumed by
// instr_issue_if and instr_issue_unit, not by this package.
package instr_issue_pkg;

  localparam int INSTR_W = 19;

  localparam logic [4:0] OP_FFT = 5'b10000;
  localparam logic [4:0] OP_ENC = 5'b10001;
  localparam logic [4:0] OP_DEC = 5'b10010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } issue_state_t;

  // True for the opcodes the CPU's custom-op datapath understands.
  function automatic logic is_custom_op(input logic [4:0] op);
    logic res;
    case (op)
      OP_FFT, OP_ENC, OP_DEC: res = 1'b1;
      default:                res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/instr_issue_if.sv
// Load / control / issue bundle of the instruction issue unit.
// master = the issue unit, slave = the loader / CPU side.
// With ISSUE_OPCODE_FILTER_EN defined the bundle also carries skip_cnt.
interface instr_issue_if #(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = 19
);
  localparam int LW = $clog2(DEPTH + 1);

  logic               load_valid;
  logic [INSTR_W-1:0] load_instr;
  logic               load_ready;
  logic               clear;
  logic               start;
  logic [3:0]         loop_cnt;
  logic               abort;
  logic               issue_valid;
  logic [INSTR_W-1:0] issue_instr;
  logic               issue_ready;
  logic               busy;
  logic               done;
  logic [LW-1:0]      prog_len;
`ifdef ISSUE_OPCODE_FILTER_EN
  logic [3:0]         skip_cnt;
`endif

  modport master (
    input  load_valid, load_instr, clear, start, loop_cnt, abort, issue_ready,
    output load_ready, issue_valid, issue_instr, busy, done, prog_len
`ifdef ISSUE_OPCODE_FILTER_EN
    , output skip_cnt
`endif
  );

  modport slave (
    output load_valid, load_instr, clear, start, loop_cnt, abort, issue_ready,
    input  load_ready, issue_valid, issue_instr, busy, done, prog_len
`ifdef ISSUE_OPCODE_FILTER_EN
    , input skip_cnt
`endif
  );

endinterface

// File: rtl/instr_prog_mem.sv
// Program storage: DEPTH x INSTR_W, synchronous write, asynchronous read.
// Contents are deliberately not reset; validity is tracked by prog_len.
module instr_prog_mem #(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = 19,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic [AW-1:0]      i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);

  logic [INSTR_W-1:0] r_mem [DEPTH];

  // Write port: one word per accepted load.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_issue_unit.sv
// Program buffer + sequencer driving the CPU instruction port.
// Optional macro ISSUE_OPCODE_FILTER_EN: skip non-custom opcodes and count
// skipped entries on skip_cnt.
module instr_issue_unit
  import instr_issue_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = instr_issue_pkg::INSTR_W
) (
  input logic           clk,
  input logic           rst,
  instr_issue_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  issue_state_t       r_state, w_state_nxt;
  logic [AW-1:0]      r_pc, w_pc_nxt;
  logic [LW-1:0]      r_prog_len, w_len_nxt;
  logic [3:0]         r_loops, w_loops_nxt;
  logic               r_issue_valid, w_valid_nxt;
  logic [INSTR_W-1:0] r_issue_instr, w_instr_nxt, w_rd_data;
  logic               r_done;
  logic               w_load_ready, w_load_fire, w_adv, w_last;

  assign w_load_ready = (r_state == ST_IDLE) && (r_prog_len < LW'(DEPTH));
  // clear wins over a same-cycle load, so such a word never lands
  assign w_load_fire  = w_load_ready && bus.load_valid && !bus.clear;
  assign w_last       = !((LW'(r_pc) + LW'(1)) < r_prog_len);

`ifdef ISSUE_OPCODE_FILTER_EN
  // a non-issued RUN cycle is a skipped entry: pc moves on as if handshaken
  assign w_adv = r_issue_valid ? bus.issue_ready : 1'b1;
`else
  assign w_adv = bus.issue_ready;
`endif

  instr_prog_mem #(.DEPTH(DEPTH), .INSTR_W(INSTR_W)) u_mem (
    .clk     (clk),
    .i_we    (w_load_fire),
    .i_waddr (r_prog_len[AW-1:0]),
    .i_wdata (bus.load_instr),
    .i_raddr (w_pc_nxt),
    .o_rdata (w_rd_data)
  );

  // Next state, pc, program length and pass counter.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_len_nxt   = r_prog_len;
    w_loops_nxt = r_loops;
    case (r_state)
      ST_IDLE: begin
        if (bus.clear) begin
          w_len_nxt = '0;
        end else if (w_load_fire) begin
          w_len_nxt = r_prog_len + LW'(1);
        end else begin
          w_len_nxt = r_prog_len;
        end
        if (bus.start) begin
          w_pc_nxt = '0;
          if (w_len_nxt != '0) begin
            w_state_nxt = ST_RUN;
            w_loops_nxt = bus.loop_cnt;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          w_state_nxt = ST_IDLE;
          w_pc_nxt    = '0;
        end else if (w_adv) begin
          if (!w_last) begin
            w_pc_nxt = r_pc + AW'(1);
          end else if (r_loops != 4'd0) begin
            w_pc_nxt    = '0;
            w_loops_nxt = r_loops - 4'd1;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_pc_nxt    = '0;
      end
    endcase
  end

  // Next issue word (bypassing a word written this very cycle) and its valid.
  always_comb begin
    if (w_load_fire && (r_prog_len[AW-1:0] == w_pc_nxt)) begin
      w_instr_nxt = bus.load_instr;
    end else begin
      w_instr_nxt = w_rd_data;
    end
`ifdef ISSUE_OPCODE_FILTER_EN
    w_valid_nxt = (w_state_nxt == ST_RUN) && is_custom_op(w_instr_nxt[INSTR_W-1 -: 5]);
`else
    w_valid_nxt = (w_state_nxt == ST_RUN);
`endif
  end

  // State and registered outputs; issue word only changes when pc can.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pc          <= '0;
      r_prog_len    <= '0;
      r_loops       <= 4'd0;
      r_issue_valid <= 1'b0;
      r_issue_instr <= '0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_prog_len    <= w_len_nxt;
      r_loops       <= w_loops_nxt;
      r_issue_valid <= w_valid_nxt;
      r_done        <= (w_state_nxt == ST_DONE);
      if (w_state_nxt == ST_RUN) begin
        r_issue_instr <= w_instr_nxt;
      end
    end
  end

`ifdef ISSUE_OPCODE_FILTER_EN
  logic [3:0] r_skip_cnt;

  // Saturating count of skipped entries, restarted by start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skip_cnt <= 4'd0;
    end else if ((r_state == ST_IDLE) && bus.start) begin
      r_skip_cnt <= 4'd0;
    end else if ((r_state == ST_RUN) && !r_issue_valid && !bus.abort &&
                 (r_skip_cnt != 4'hF)) begin
      r_skip_cnt <= r_skip_cnt + 4'd1;
    end
  end

  assign bus.skip_cnt = r_skip_cnt;
`endif

  assign bus.load_ready  = w_load_ready;
  assign bus.issue_valid = r_issue_valid;
  assign bus.issue_instr = r_issue_instr;
  assign bus.busy        = (r_state == ST_RUN);
  assign bus.done        = r_done;
  assign bus.prog_len    = r_prog_len;

endmodule
